// File: rtl/vga_sync_receiver.sv
// Receive side of the 800x521 VGA stream: recovers pixel coordinates, checks sync timing, locks on and flags valid pixels.
// Optional macro VGA_RX_WINDOW_EN limits valid pixels to a WIN_SIZE square and reports window-relative coordinates.
module vga_sync_receiver #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 521,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WIN_X0   = 240,
  parameter int WIN_Y0   = 141,
  parameter int WIN_SIZE = 256
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPixelEnable,
  input  logic       iHsync,
  input  logic       iVsync,
  input  logic [2:0] iRGB,
  output logic [2:0] oRGB,
  output logic [9:0] oHcounter,
  output logic [9:0] oVcounter,
  output logic       oPixelValid,
  output logic       oFrameStart,
  output logic       oLocked,
  output logic       oSyncError,
  output logic [7:0] oErrorCount
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t     state, stateNext;
  logic       hsPrev, vsPrev;
  logic [9:0] hCount, vCount, hNext, vNext;
  logic       hRise, vRise;
  logic       lineErr, frameErr, strayVErr, violation;
  logic       validNext, frameStartNext;
  logic [9:0] hOut, vOut;

`ifdef VGA_RX_WINDOW_EN
  localparam logic [9:0] WX0 = 10'(WIN_X0);
  localparam logic [9:0] WY0 = 10'(WIN_Y0);
  localparam logic [9:0] WXE = 10'(WIN_X0 + WIN_SIZE);
  localparam logic [9:0] WYE = 10'(WIN_Y0 + WIN_SIZE);
`else
  logic unusedWinParams;
  assign unusedWinParams = ^{10'(WIN_X0), 10'(WIN_Y0), 10'(WIN_SIZE)};
`endif

  assign oLocked = (state == LOCKED);

  always_comb begin
    hRise     = iHsync & ~hsPrev;
    vRise     = iVsync & ~vsPrev;
    hNext     = hRise ? 10'd0 : ((hCount == 10'h3FF) ? hCount : hCount + 10'd1);
    vNext     = vCount;
    if (hRise) begin
      vNext = vRise ? 10'd0 : ((vCount == 10'h3FF) ? vCount : vCount + 10'd1);
    end
    // Timing is only policed once we have seen a frame start; SEARCH just waits.
    lineErr   = hRise != (hCount == H_LAST);
    frameErr  = hRise & (vRise != (vCount == V_LAST));
    strayVErr = vRise & ~hRise;
    violation = iPixelEnable & (state != SEARCH) & (lineErr | frameErr | strayVErr);

    stateNext = state;
    if (iPixelEnable) begin
      case (state)
        SEARCH:  if (hRise && vRise) stateNext = VERIFY;
        VERIFY:  if (violation) stateNext = SEARCH;
                 else if (vRise) stateNext = LOCKED;
        LOCKED:  if (violation) stateNext = SEARCH;
        default: stateNext = SEARCH;
      endcase
    end

    // Output flags use the post-sample state, so a violating sample is never valid.
`ifdef VGA_RX_WINDOW_EN
    validNext      = (stateNext == LOCKED) && (hNext < H_ACT) && (vNext < V_ACT) &&
                     (hNext >= WX0) && (hNext < WXE) && (vNext >= WY0) && (vNext < WYE);
    hOut           = validNext ? hNext - WX0 : 10'd0;
    vOut           = validNext ? vNext - WY0 : 10'd0;
    frameStartNext = validNext && (hNext == WX0) && (vNext == WY0);
`else
    validNext      = (stateNext == LOCKED) && (hNext < H_ACT) && (vNext < V_ACT);
    hOut           = hNext;
    vOut           = vNext;
    frameStartNext = (stateNext == LOCKED) && (hNext == 10'd0) && (vNext == 10'd0);
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= SEARCH;
      hsPrev      <= 1'b1;
      vsPrev      <= 1'b1;
      hCount      <= '0;
      vCount      <= '0;
      oRGB        <= '0;
      oHcounter   <= '0;
      oVcounter   <= '0;
      oPixelValid <= 1'b0;
      oFrameStart <= 1'b0;
      oSyncError  <= 1'b0;
      oErrorCount <= '0;
    end else begin
      state       <= stateNext;
      oSyncError  <= violation;
      oFrameStart <= 1'b0;
      if (violation && oErrorCount != 8'hFF) begin
        oErrorCount <= oErrorCount + 8'd1;
      end
      if (iPixelEnable) begin
        hsPrev      <= iHsync;
        vsPrev      <= iVsync;
        hCount      <= hNext;
        vCount      <= vNext;
        oRGB        <= iRGB;
        oHcounter   <= hOut;
        oVcounter   <= vOut;
        oPixelValid <= validNext;
        oFrameStart <= frameStartNext;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled 16x10 raster; define VGA_RX_WINDOW_EN for the windowed build.
module tb_vga_sync_receiver;

  localparam int H_T = 16, V_T = 10, H_A = 10, V_A = 6;
  localparam int HS_LOW = 14, VS_LOW = 8;
  localparam int WX = 2, WY = 1, WS = 4;
`ifdef VGA_RX_WINDOW_EN
  localparam int EXP_PV = WS * WS;
  localparam int EXP_FIRST_H = WX, EXP_FIRST_V = WY, EXP_LAST_H = WS - 1, EXP_LAST_V = WS - 1;
`else
  localparam int EXP_PV = H_A * V_A;
  localparam int EXP_FIRST_H = 0, EXP_FIRST_V = 0, EXP_LAST_H = H_A - 1, EXP_LAST_V = V_A - 1;
`endif

  logic       Clock = 1'b0;
  logic       Reset, iPixelEnable, iHsync, iVsync;
  logic [2:0] iRGB, oRGB;
  logic [9:0] oHcounter, oVcounter;
  logic       oPixelValid, oFrameStart, oLocked, oSyncError;
  logic [7:0] oErrorCount;

  vga_sync_receiver #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACTIVE(H_A), .V_ACTIVE(V_A),
    .WIN_X0(WX), .WIN_Y0(WY), .WIN_SIZE(WS)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iPixelEnable(iPixelEnable),
    .iHsync(iHsync), .iVsync(iVsync), .iRGB(iRGB),
    .oRGB(oRGB), .oHcounter(oHcounter), .oVcounter(oVcounter),
    .oPixelValid(oPixelValid), .oFrameStart(oFrameStart), .oLocked(oLocked),
    .oSyncError(oSyncError), .oErrorCount(oErrorCount)
  );

  always #5 Clock = ~Clock;

  int checks = 0, errors = 0;
  int pvCount, fsCount, errPulses, idlePulses = 0;
  int lockIdx, sampleIdx, firstH, firstV, firstRepH, firstRepV, lastRepH, lastRepV;
  logic seenValid, lockedAtErr, pvAtErr, checkCoords;
  logic [24:0] expQ[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clearStats();
    pvCount = 0; fsCount = 0; errPulses = 0; lockIdx = -1; sampleIdx = 0;
    seenValid = 0; lockedAtErr = 1; pvAtErr = 1;
    firstH = -1; firstV = -1; firstRepH = -1; firstRepV = -1; lastRepH = -1; lastRepV = -1;
  endtask

  function automatic logic [24:0] expVec(input int h, input int v, input logic [2:0] rgb);
    logic valid, fs;
    logic [9:0] eh, ev;
`ifdef VGA_RX_WINDOW_EN
    valid = (h >= WX) && (h < WX + WS) && (v >= WY) && (v < WY + WS);
    eh = valid ? 10'(h - WX) : 10'd0;
    ev = valid ? 10'(v - WY) : 10'd0;
    fs = (h == WX) && (v == WY);
`else
    valid = (h < H_A) && (v < V_A);
    eh = 10'(h);
    ev = 10'(v);
    fs = (h == 0) && (v == 0);
`endif
    return {fs, valid, rgb, eh, ev};
  endfunction

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_rgb"}, 32'(oRGB), 0);
    chk({tag, "_h"}, 32'(oHcounter), 0);
    chk({tag, "_v"}, 32'(oVcounter), 0);
    chk({tag, "_pv"}, 32'(oPixelValid), 0);
    chk({tag, "_fs"}, 32'(oFrameStart), 0);
    chk({tag, "_lock"}, 32'(oLocked), 0);
    chk({tag, "_serr"}, 32'(oSyncError), 0);
    chk({tag, "_ecnt"}, 32'(oErrorCount), 0);
  endtask

  // One sample clock followed by one idle clock.
  task automatic doSample(input logic hs, input logic vs, input logic [2:0] rgb, input int h, input int v);
    logic [24:0] e;
    iHsync = hs; iVsync = vs; iRGB = rgb; iPixelEnable = 1'b1;
    @(posedge Clock); #1;
    pvCount += int'(oPixelValid);
    fsCount += int'(oFrameStart);
    if (oSyncError) begin
      errPulses++;
      lockedAtErr = oLocked;
      pvAtErr = oPixelValid;
    end
    if (oLocked && lockIdx < 0) lockIdx = sampleIdx;
    if (oPixelValid) begin
      if (!seenValid) begin
        seenValid = 1; firstH = h; firstV = v; firstRepH = int'(oHcounter); firstRepV = int'(oVcounter);
      end
      lastRepH = int'(oHcounter); lastRepV = int'(oVcounter);
    end
    sampleIdx++;
    e = '0;
    if (checkCoords && expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("px_fs", 32'(oFrameStart), 32'(e[24]));
      chk("px_pv", 32'(oPixelValid), 32'(e[23]));
      chk("px_rgb", 32'(oRGB), 32'(e[22:20]));
      chk("px_h", 32'(oHcounter), 32'(e[19:10]));
      chk("px_v", 32'(oVcounter), 32'(e[9:0]));
    end
    iPixelEnable = 1'b0;
    iRGB = ~rgb;
    @(posedge Clock); #1;
    idlePulses += int'(oFrameStart | oSyncError);
    if (checkCoords) begin
      chk("hold_rgb", 32'(oRGB), 32'(e[22:20]));
      chk("hold_pv", 32'(oPixelValid), 32'(e[23]));
    end
  endtask

  task automatic sendFrame(input int shortLine, input int vsDelay, input int resetV, input int resetH);
    int len;
    logic hs, vs;
    logic [2:0] rgb;
    for (int v = 0; v < V_T; v++) begin
      len = (v == shortLine) ? H_T - 1 : H_T;
      for (int h = 0; h < len; h++) begin
        hs  = (h < HS_LOW);
        vs  = (v < VS_LOW) && !(v == 0 && h < vsDelay);
        rgb = 3'(h + v);
        if (v == resetV && h == resetH) begin
          iHsync = hs; iVsync = vs; iRGB = rgb; iPixelEnable = 1'b1; Reset = 1'b1;
          @(posedge Clock); #1;
          Reset = 1'b0; iPixelEnable = 1'b0;
          checkResetOutputs("midrst");
          @(posedge Clock); #1;
        end else begin
          if (checkCoords) expQ.push_back(expVec(h, v, rgb));
          doSample(hs, vs, rgb, h, v);
        end
      end
    end
  endtask

  task automatic pulseReset();
    Reset = 1'b1; iPixelEnable = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; iPixelEnable = 1'b0; iHsync = 1'b0; iVsync = 1'b0; iRGB = 3'd5;
    checkCoords = 0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    checkResetOutputs("rst");

    // Clean stream, starting with the last sample of a previous frame.
    clearStats();
    doSample(1'b0, 1'b0, 3'd0, H_T - 1, V_T - 1);
    clearStats();
    sendFrame(-1, 0, -1, -1);
    chk("f1_lockidx", 32'(lockIdx), 32'(-1));
    chk("f1_fs", 32'(fsCount), 0);
    chk("f1_pv", 32'(pvCount), 0);
    clearStats();
    checkCoords = 1;
    sendFrame(-1, 0, -1, -1);
    checkCoords = 0;
    chk("f2_lockidx", 32'(lockIdx), 0);
    chk("f2_fs", 32'(fsCount), 1);
    chk("f2_pv", 32'(pvCount), 32'(EXP_PV));
    chk("f2_first_h", 32'(firstH), 32'(EXP_FIRST_H));
    chk("f2_first_v", 32'(firstV), 32'(EXP_FIRST_V));
    chk("f2_first_rep_h", 32'(firstRepH), 32'(EXP_FIRST_H - ((EXP_PV == H_A * V_A) ? 0 : WX)));
    chk("f2_first_rep_v", 32'(firstRepV), 32'(EXP_FIRST_V - ((EXP_PV == H_A * V_A) ? 0 : WY)));
    chk("f2_last_rep_h", 32'(lastRepH), 32'(EXP_LAST_H));
    chk("f2_last_rep_v", 32'(lastRepV), 32'(EXP_LAST_V));
    clearStats();
    sendFrame(-1, 0, -1, -1);
    chk("f3_fs", 32'(fsCount), 1);
    chk("f3_pv", 32'(pvCount), 32'(EXP_PV));
    chk("f3_err", 32'(errPulses), 0);
    chk("f3_ecnt", 32'(oErrorCount), 0);

    // Line 3 one sample short while locked.
    clearStats();
    sendFrame(3, 0, -1, -1);
    chk("short_err", 32'(errPulses), 1);
    chk("short_ecnt", 32'(oErrorCount), 1);
    chk("short_lock_at_err", 32'(lockedAtErr), 0);
    chk("short_pv_at_err", 32'(pvAtErr), 0);
    chk("short_lock_end", 32'(oLocked), 0);
    clearStats();
    sendFrame(-1, 0, -1, -1);
    chk("short_verify_lock", 32'(oLocked), 0);
    chk("short_verify_fs", 32'(fsCount), 0);
    clearStats();
    sendFrame(-1, 0, -1, -1);
    chk("short_relock_idx", 32'(lockIdx), 0);
    chk("short_relock_fs", 32'(fsCount), 1);

    // Vsync rise 5 samples late.
    clearStats();
    sendFrame(-1, 5, -1, -1);
    chk("vlate_err", 32'(errPulses), 1);
    chk("vlate_ecnt", 32'(oErrorCount), 2);
    chk("vlate_fs", 32'(fsCount), 0);
    chk("vlate_lock", 32'(oLocked), 0);
    clearStats();
    sendFrame(-1, 0, -1, -1);
    chk("vlate_verify_fs", 32'(fsCount), 0);
    clearStats();
    sendFrame(-1, 0, -1, -1);
    chk("vlate_relock_fs", 32'(fsCount), 1);
    chk("vlate_relock_lock", 32'(oLocked), 1);

    // Reset mid-frame while locked, then relock.
    clearStats();
    sendFrame(-1, 0, 4, 7);
    chk("rst_err", 32'(errPulses), 0);
    chk("rst_lock", 32'(oLocked), 0);
    clearStats();
    sendFrame(-1, 0, -1, -1);
    chk("rst_verify_lockidx", 32'(lockIdx), 32'(-1));
    clearStats();
    sendFrame(-1, 0, -1, -1);
    chk("rst_relock_idx", 32'(lockIdx), 0);
    chk("rst_relock_fs", 32'(fsCount), 1);
    chk("rst_relock_pv", 32'(pvCount), 32'(EXP_PV));

    // Repeated violations: enter VERIFY then break the line length.
    pulseReset();
    clearStats();
    for (int i = 0; i < 300; i++) begin
      doSample(1'b0, 1'b0, 3'd1, 0, 0);
      doSample(1'b1, 1'b1, 3'd2, 0, 0);
      doSample(1'b0, 1'b0, 3'd3, 0, 0);
      doSample(1'b1, 1'b1, 3'd4, 0, 0);
      if (i == 9) chk("sat_ecnt10", 32'(oErrorCount), 10);
    end
    chk("sat_pulses", 32'(errPulses), 300);
    chk("sat_ecnt", 32'(oErrorCount), 255);
    chk("sat_lock", 32'(oLocked), 0);
    chk("idle_pulses", 32'(idlePulses), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
